// File: rtl/insn_sequencer.sv
// insn_sequencer: multi-cycle instruction-execution control sequencer.
//
// Steps each instruction through FETCH, DECODE, an execute or memory phase,
// and WRITEBACK. A one-hot state register drives the decoder stage code
// directly. Illegal opcodes park the machine in TRAP until reset.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   insn       in  32   memory read data in FETCH, IR output afterwards
//   mem_ready  in   1   memory access completes in the cycle this is high
//   code       out 10   one-hot stage code (the state register itself)
//   mem_req    out  1   memory access request
//   mem_we     out  1   memory write enable (store)
//   insn_we    out  1   instruction-register load strobe
//   pc_we      out  1   PC update strobe
//   rd_we      out  1   register-file write strobe
//   trap       out  1   sticky illegal-instruction flag
//   instret    out 32   retired-instruction counter (wraps)
module insn_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] insn,
    input  logic        mem_ready,
    output logic [9:0]  code,
    output logic        mem_req,
    output logic        mem_we,
    output logic        insn_we,
    output logic        pc_we,
    output logic        rd_we,
    output logic        trap,
    output logic [31:0] instret
);

    typedef enum logic [9:0] {
        FETCH       = 10'h001,
        DECODE      = 10'h002,
        EXEC_ALU    = 10'h004,
        EXEC_JUMP   = 10'h008,
        EXEC_BRANCH = 10'h010,
        MEM_ADDR    = 10'h020,
        MEM_LOAD    = 10'h040,
        MEM_STORE   = 10'h080,
        WRITEBACK   = 10'h100,
        TRAP        = 10'h200
    } state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    state_t     state;
    state_t     state_next;
    logic       retire;
    logic [6:0] opcode;

    assign opcode = insn[6:0];
    assign code   = state;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        insn_we    = 1'b0;
        pc_we      = 1'b0;
        rd_we      = 1'b0;
        retire     = 1'b0;

        unique case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    insn_we    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                unique case (opcode)
                    OP_REG, OP_IMM, OP_LUI, OP_AUIPC: state_next = EXEC_ALU;
                    OP_JAL, OP_JALR:                  state_next = EXEC_JUMP;
                    OP_BRANCH:                        state_next = EXEC_BRANCH;
                    OP_LOAD, OP_STORE:                state_next = MEM_ADDR;
                    OP_FENCE:                         state_next = WRITEBACK;
                    default:                          state_next = TRAP;
                endcase
            end
            EXEC_ALU, EXEC_JUMP: state_next = WRITEBACK;
            EXEC_BRANCH: begin
                // Taken/not-taken is the decoder's job; the PC always updates.
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: state_next = (opcode == OP_LOAD) ? MEM_LOAD : MEM_STORE;
            MEM_LOAD: begin
                mem_req = 1'b1;
                if (mem_ready) state_next = WRITEBACK;
            end
            MEM_STORE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            WRITEBACK: begin
                pc_we      = 1'b1;
                retire     = 1'b1;
                // x0 is never written, and FENCE has no destination.
                rd_we      = (insn[11:7] != 5'd0) && (opcode != OP_FENCE);
                state_next = FETCH;
            end
            TRAP: state_next = TRAP;
            default: state_next = FETCH;  // recover from a corrupted encoding
        endcase

        // Reset kills any in-flight access in the same cycle.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            insn_we = 1'b0;
            pc_we   = 1'b0;
            rd_we   = 1'b0;
            retire  = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            trap    <= 1'b0;
            instret <= 32'd0;
        end else begin
            state <= state_next;
            if (state_next == TRAP) trap <= 1'b1;
            if (retire) instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_insn_sequencer.sv
// tb_insn_sequencer: directed, scoreboard-based bench for insn_sequencer.
// Each step drives inputs just after a rising edge, queues the outputs the
// sequencer must show in that cycle, and compares them on the falling edge.
module tb_insn_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] insn;
    logic        mem_ready;
    logic [9:0]  code;
    logic        mem_req;
    logic        mem_we;
    logic        insn_we;
    logic        pc_we;
    logic        rd_we;
    logic        trap;
    logic [31:0] instret;

    typedef struct packed {
        logic [9:0]  code;
        logic [4:0]  strb;  // {mem_req, mem_we, insn_we, pc_we, rd_we}
        logic        trap;
        logic [31:0] instret;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_REQ   = 5'b10000;
    localparam logic [4:0] S_FRDY  = 5'b10100;
    localparam logic [4:0] S_PC    = 5'b00010;
    localparam logic [4:0] S_PCRD  = 5'b00011;
    localparam logic [4:0] S_STW   = 5'b11000;
    localparam logic [4:0] S_STRDY = 5'b11010;

    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_BEQ   = 32'h00520463;
    localparam logic [31:0] I_SW    = 32'h0011A023;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_ILL   = 32'h00000000;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_FENCE = 32'h0000008F;

    insn_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .insn      (insn),
        .mem_ready (mem_ready),
        .code      (code),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .insn_we   (insn_we),
        .pc_we     (pc_we),
        .rd_we     (rd_we),
        .trap      (trap),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic rst, input logic [31:0] ins,
                       input logic rdy, input logic [9:0] e_code, input logic [4:0] e_strb,
                       input logic e_trap, input logic [31:0] e_instret);
        obs_t obs;
        obs_t exp;
        @(posedge clk);
        #1;
        reset     = rst;
        insn      = ins;
        mem_ready = rdy;
        exp_q.push_back('{code: e_code, strb: e_strb, trap: e_trap, instret: e_instret});
        @(negedge clk);
        obs = '{code: code, strb: {mem_req, mem_we, insn_we, pc_we, rd_we},
                trap: trap, instret: instret};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed code=%h strb=%b trap=%b instret=%0d expected code=%h strb=%b trap=%b instret=%0d",
                   tag, obs.code, obs.strb, obs.trap, obs.instret,
                   exp.code, exp.strb, exp.trap, exp.instret);
        end
    endtask

    initial begin
        reset     = 1'b1;
        insn      = 32'd0;
        mem_ready = 1'b0;

        // Two reset cycles, then release into FETCH with mem_req high.
        cyc("rst_a",          1, I_ADDI, 0, 10'h001, S_NONE, 0, 0);
        cyc("rst_b",          1, I_ADDI, 0, 10'h001, S_NONE, 0, 0);
        cyc("rel_fetch",      0, I_ADDI, 0, 10'h001, S_REQ,  0, 0);

        // ADDI x1: ready on the second FETCH cycle, writes rd.
        cyc("addi_fetch_rdy", 0, I_ADDI, 1, 10'h001, S_FRDY, 0, 0);
        cyc("addi_decode",    0, I_ADDI, 0, 10'h002, S_NONE, 0, 0);
        cyc("addi_exec",      0, I_ADDI, 0, 10'h004, S_NONE, 0, 0);
        cyc("addi_wb",        0, I_ADDI, 0, 10'h100, S_PCRD, 0, 0);

        // NOP (rd = x0): no register write; stray mem_ready in EXEC ignored.
        cyc("nop_fetch",      0, I_NOP,  1, 10'h001, S_FRDY, 0, 1);
        cyc("nop_decode",     0, I_NOP,  0, 10'h002, S_NONE, 0, 1);
        cyc("nop_exec",       0, I_NOP,  1, 10'h004, S_NONE, 0, 1);
        cyc("nop_wb",         0, I_NOP,  0, 10'h100, S_PC,   0, 1);

        // BEQ: PC update and retire from EXEC_BRANCH, straight back to FETCH.
        cyc("beq_fetch",      0, I_BEQ,  1, 10'h001, S_FRDY, 0, 2);
        cyc("beq_decode",     0, I_BEQ,  0, 10'h002, S_NONE, 0, 2);
        cyc("beq_exec",       0, I_BEQ,  0, 10'h010, S_PC,   0, 2);

        // SW with three wait cycles in MEM_STORE.
        cyc("sw_fetch",       0, I_SW,   1, 10'h001, S_FRDY, 0, 3);
        cyc("sw_decode",      0, I_SW,   0, 10'h002, S_NONE, 0, 3);
        cyc("sw_addr",        0, I_SW,   1, 10'h020, S_NONE, 0, 3);
        cyc("sw_wait1",       0, I_SW,   0, 10'h080, S_STW,  0, 3);
        cyc("sw_wait2",       0, I_SW,   0, 10'h080, S_STW,  0, 3);
        cyc("sw_wait3",       0, I_SW,   0, 10'h080, S_STW,  0, 3);
        cyc("sw_ready",       0, I_SW,   1, 10'h080, S_STRDY, 0, 3);

        // Reset clears instret, then a load is abandoned by reset mid-access.
        cyc("pre_ld_reset",   1, I_LW,   0, 10'h001, S_NONE, 0, 4);
        cyc("ld_fetch",       0, I_LW,   1, 10'h001, S_FRDY, 0, 0);
        cyc("ld_decode",      0, I_LW,   0, 10'h002, S_NONE, 0, 0);
        cyc("ld_addr",        0, I_LW,   0, 10'h020, S_NONE, 0, 0);
        cyc("ld_wait",        0, I_LW,   0, 10'h040, S_REQ,  0, 0);
        cyc("ld_reset",       1, I_LW,   0, 10'h040, S_NONE, 0, 0);
        cyc("ld_after",       0, I_LW,   0, 10'h001, S_REQ,  0, 0);

        // Illegal opcode: TRAP held for 10 cycles, mem_ready toggling ignored.
        cyc("ill_fetch",      0, I_ILL,  1, 10'h001, S_FRDY, 0, 0);
        cyc("ill_decode",     0, I_ILL,  0, 10'h002, S_NONE, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc("ill_hold",   0, I_ILL,  logic'(i % 2), 10'h200, S_NONE, 1, 0);
        cyc("ill_reset",      1, I_ILL,  0, 10'h200, S_NONE, 1, 0);
        cyc("ill_after",      0, I_JAL,  0, 10'h001, S_REQ,  0, 0);

        // JAL x1 goes through EXEC_JUMP and writes rd.
        cyc("jal_fetch",      0, I_JAL,  1, 10'h001, S_FRDY, 0, 0);
        cyc("jal_decode",     0, I_JAL,  0, 10'h002, S_NONE, 0, 0);
        cyc("jal_exec",       0, I_JAL,  0, 10'h008, S_NONE, 0, 0);
        cyc("jal_wb",         0, I_JAL,  0, 10'h100, S_PCRD, 0, 0);

        // FENCE with rd field nonzero: straight to WRITEBACK, no rd write.
        cyc("fence_fetch",    0, I_FENCE, 1, 10'h001, S_FRDY, 0, 1);
        cyc("fence_decode",   0, I_FENCE, 0, 10'h002, S_NONE, 0, 1);
        cyc("fence_wb",       0, I_FENCE, 0, 10'h100, S_PC,   0, 1);
        cyc("final_fetch",    0, I_FENCE, 0, 10'h001, S_REQ,  0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
